// File: rtl/sdram_master_port.sv
// ---------------------------------------------------------------------------
// sdram_master_port
//
// FPGA-side initiator for the HPS SDRAM conduit. Accepts one CPU load/store
// request at a time (byte, half or word), turns it into a single 32-bit
// word-addressed conduit transfer with lane byte enables, holds the strobe
// until the conduit acknowledges or a timeout expires, then returns a
// one-cycle response pulse.
//
// Ports
//   clk_clk, reset_reset          clock, synchronous active-high reset
//   cpu_req_valid/ready           request handshake (ready only while idle)
//   cpu_req_write/addr/size/wdata request fields (byte address, size 0/1/2)
//   cpu_rsp_valid/rdata/error     one-cycle response, load data zero-extended
//   sdram_address/byte_enable     conduit word address and lane enables
//   sdram_read/sdram_write        conduit strobes (never both high)
//   sdram_write_data              lane-placed store data
//   sdram_acknowledge/read_data   conduit completion and load data
// ---------------------------------------------------------------------------
module sdram_master_port #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_write,
    input  logic [ADDR_WIDTH+1:0] cpu_req_addr,
    input  logic [1:0]            cpu_req_size,
    input  logic [31:0]           cpu_req_wdata,
    output logic                  cpu_rsp_valid,
    output logic [31:0]           cpu_rsp_rdata,
    output logic                  cpu_rsp_error,
    output logic [ADDR_WIDTH-1:0] sdram_address,
    output logic [3:0]            sdram_byte_enable,
    output logic                  sdram_read,
    output logic                  sdram_write,
    output logic [31:0]           sdram_write_data,
    input  logic                  sdram_acknowledge,
    input  logic [31:0]           sdram_read_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RSP  = 2'd2;

    // Counter counts completed REQ cycles; the last allowed cycle is the one
    // where it holds TIMEOUT_CYCLES-1.
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Size/alignment legality: half needs addr[0]=0, word needs addr[1:0]=0.
    function automatic logic req_legal(input logic [1:0] size, input logic [1:0] lane);
        logic ok;
        case (size)
            2'd0:    ok = 1'b1;
            2'd1:    ok = ~lane[0];
            2'd2:    ok = (lane == 2'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte enables for the lanes touched by the access.
    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001 << lane;
            2'd1:    be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated across lanes so the enabled lanes carry it.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            2'd0:    d = {4{wdata[7:0]}};
            2'd1:    d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Pull the addressed lanes down to bit 0 and zero-extend.
    function automatic logic [31:0] extract_load(input logic [1:0] size, input logic [1:0] lane,
                                                 input logic [31:0] rd);
        logic [31:0] shifted;
        logic [31:0] r;
        shifted = rd >> {lane, 3'b000};
        case (size)
            2'd0:    r = {24'h000000, shifted[7:0]};
            2'd1:    r = {16'h0000, shifted[15:0]};
            default: r = rd;
        endcase
        return r;
    endfunction

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            lane_q, lane_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_error_q, rsp_error_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  sdram_read_q, sdram_read_d;
    logic                  sdram_write_q, sdram_write_d;
    logic [ADDR_WIDTH-1:0] sdram_address_q, sdram_address_d;
    logic [3:0]            sdram_be_q, sdram_be_d;
    logic [31:0]           sdram_wdata_q, sdram_wdata_d;

    logic [1:0]            req_lane_s;
    assign req_lane_s = cpu_req_addr[1:0];

    // Next-state and output computation for the IDLE/REQ/RSP sequencer.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        wr_d            = wr_q;
        size_d          = size_q;
        lane_d          = lane_q;
        rsp_valid_d     = 1'b0;
        rsp_error_d     = 1'b0;
        rsp_rdata_d     = rsp_rdata_q;
        sdram_read_d    = sdram_read_q;
        sdram_write_d   = sdram_write_q;
        sdram_address_d = sdram_address_q;
        sdram_be_d      = sdram_be_q;
        sdram_wdata_d   = sdram_wdata_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (cpu_req_valid && req_ready_q) begin
                    wr_d   = cpu_req_write;
                    size_d = cpu_req_size;
                    lane_d = req_lane_s;
                    if (req_legal(cpu_req_size, req_lane_s)) begin
                        state_d         = ST_REQ;
                        sdram_read_d    = ~cpu_req_write;
                        sdram_write_d   = cpu_req_write;
                        sdram_address_d = cpu_req_addr[ADDR_WIDTH+1:2];
                        sdram_be_d      = lane_enables(cpu_req_size, req_lane_s);
                        sdram_wdata_d   = cpu_req_write ? lane_data(cpu_req_size, cpu_req_wdata)
                                                        : 32'h00000000;
                    end else begin
                        // Rejected without touching the conduit.
                        state_d     = ST_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = 32'h00000000;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Acknowledge takes priority over a coincident timeout.
                if (sdram_acknowledge) begin
                    state_d       = ST_RSP;
                    cnt_d         = {CNT_W{1'b0}};
                    sdram_read_d  = 1'b0;
                    sdram_write_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = wr_q ? 32'h00000000
                                         : extract_load(size_q, lane_q, sdram_read_data);
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = ST_RSP;
                    cnt_d         = {CNT_W{1'b0}};
                    sdram_read_d  = 1'b0;
                    sdram_write_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_error_d   = 1'b1;
                    rsp_rdata_d   = 32'h00000000;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RSP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d       = ST_IDLE;
                cnt_d         = {CNT_W{1'b0}};
                sdram_read_d  = 1'b0;
                sdram_write_d = 1'b0;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= {CNT_W{1'b0}};
            wr_q            <= 1'b0;
            size_q          <= 2'd0;
            lane_q          <= 2'd0;
            req_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_error_q     <= 1'b0;
            rsp_rdata_q     <= 32'h00000000;
            sdram_read_q    <= 1'b0;
            sdram_write_q   <= 1'b0;
            sdram_address_q <= {ADDR_WIDTH{1'b0}};
            sdram_be_q      <= 4'b0000;
            sdram_wdata_q   <= 32'h00000000;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            wr_q            <= wr_d;
            size_q          <= size_d;
            lane_q          <= lane_d;
            req_ready_q     <= req_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_error_q     <= rsp_error_d;
            rsp_rdata_q     <= rsp_rdata_d;
            sdram_read_q    <= sdram_read_d;
            sdram_write_q   <= sdram_write_d;
            sdram_address_q <= sdram_address_d;
            sdram_be_q      <= sdram_be_d;
            sdram_wdata_q   <= sdram_wdata_d;
        end
    end

    assign cpu_req_ready     = req_ready_q;
    assign cpu_rsp_valid     = rsp_valid_q;
    assign cpu_rsp_error     = rsp_error_q;
    assign cpu_rsp_rdata     = rsp_rdata_q;
    assign sdram_read        = sdram_read_q;
    assign sdram_write       = sdram_write_q;
    assign sdram_address     = sdram_address_q;
    assign sdram_byte_enable = sdram_be_q;
    assign sdram_write_data  = sdram_wdata_q;

endmodule

// File: tb/tb_sdram_master_port.sv
// ---------------------------------------------------------------------------
// tb_sdram_master_port
//
// Driver issues CPU requests and pushes expectations (conduit transfer and
// CPU response) computed from a lane-arithmetic reference model into queues.
// A conduit responder pops conduit expectations when a strobe appears,
// checks the strobe fields every cycle and acknowledges after the planned
// delay. A response monitor pops and compares whenever cpu_rsp_valid is high.
// ---------------------------------------------------------------------------
module tb_sdram_master_port;

    localparam int AW = 16;
    localparam int TO = 4;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [31:0]   wdata;
        int            delay;
        logic [31:0]   rdata;
        bit            aborted;
    } conduit_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic          clk_clk = 1'b0;
    logic          reset_reset = 1'b1;
    logic          cpu_req_valid = 1'b0;
    logic          cpu_req_ready;
    logic          cpu_req_write = 1'b0;
    logic [AW+1:0] cpu_req_addr = '0;
    logic [1:0]    cpu_req_size = 2'd0;
    logic [31:0]   cpu_req_wdata = 32'h0;
    logic          cpu_rsp_valid;
    logic [31:0]   cpu_rsp_rdata;
    logic          cpu_rsp_error;
    logic [AW-1:0] sdram_address;
    logic [3:0]    sdram_byte_enable;
    logic          sdram_read;
    logic          sdram_write;
    logic [31:0]   sdram_write_data;
    logic          sdram_acknowledge;
    logic [31:0]   sdram_read_data = 32'h0;
    logic          resp_ack = 1'b0;
    logic          stray_ack = 1'b0;

    assign sdram_acknowledge = resp_ack | stray_ack;

    sdram_master_port #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_write(cpu_req_write), .cpu_req_addr(cpu_req_addr),
        .cpu_req_size(cpu_req_size), .cpu_req_wdata(cpu_req_wdata),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata),
        .cpu_rsp_error(cpu_rsp_error),
        .sdram_address(sdram_address), .sdram_byte_enable(sdram_byte_enable),
        .sdram_read(sdram_read), .sdram_write(sdram_write),
        .sdram_write_data(sdram_write_data),
        .sdram_acknowledge(sdram_acknowledge), .sdram_read_data(sdram_read_data)
    );

    always #5 clk_clk = ~clk_clk;

    int       total = 0;
    int       passed = 0;
    conduit_t cq[$];
    rsp_t     rq[$];
    bit       in_txn = 1'b0;
    bit       has_prev = 1'b0;
    time      prev_t = 0;
    int       prev_sp = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else passed++;
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_legal(input int size, input logic [AW+1:0] addr);
        int b = int'(addr[1:0]);
        if (size == 3) return 1'b0;
        return (b % (1 << size)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input int size, input int b);
        int bytes = 1 << size;
        return 4'(((1 << bytes) - 1) << b);
    endfunction

    function automatic logic [31:0] m_wdata(input int size, input logic [31:0] w);
        logic [31:0] r;
        int bytes = 1 << size;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % bytes) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_rdata(input int size, input int b, input logic [31:0] rd);
        logic [63:0] mask;
        logic [63:0] v;
        mask = (64'd1 << (8 * (1 << size))) - 64'd1;
        v = ({32'h0, rd} >> (8 * b)) & mask;
        return v[31:0];
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input bit wr, input logic [AW+1:0] addr, input int size,
                         input logic [31:0] wdata, input int delay, input logic [31:0] rd,
                         input bit chk, input bit abort);
        conduit_t c;
        rsp_t     r;
        bit       legal;
        int       b;
        int       sp;
        time      t;
        legal = m_legal(size, addr);
        b = int'(addr[1:0]);
        if (legal) begin
            c.wr = wr; c.addr = addr[AW+1:2]; c.be = m_be(size, b);
            c.wdata = m_wdata(size, wdata); c.rdata = rd;
            c.delay = abort ? 99 : delay; c.aborted = abort;
            cq.push_back(c);
        end
        if (!abort) begin
            if (!legal || delay >= TO) begin r.err = 1'b1; r.rdata = 32'h0; end
            else begin r.err = 1'b0; r.rdata = wr ? 32'h0 : m_rdata(size, b, rd); end
            rq.push_back(r);
        end
        sp = !legal ? 2 : (delay < TO ? 3 + delay : TO + 2);
        cpu_req_valid = 1'b1; cpu_req_write = wr; cpu_req_addr = addr;
        cpu_req_size = 2'(size); cpu_req_wdata = wdata;
        for (int i = 0; i < 50 && !cpu_req_ready; i++) @(negedge clk_clk);
        check("req_ready_wait", {31'h0, cpu_req_ready}, 32'h1);
        t = $time;
        @(negedge clk_clk);
        cpu_req_valid = 1'b0;
        if (chk && has_prev) check("req_spacing", 32'((t - prev_t) / 10), 32'(prev_sp));
        has_prev = !abort;
        prev_t = t;
        prev_sp = sp;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && (rq.size() != 0 || in_txn); i++) @(negedge clk_clk);
        check("idle_wait", {31'h0, (rq.size() == 0 && !in_txn)}, 32'h1);
    endtask

    // ---------------- conduit responder / monitor ----------------
    initial begin : responder
        conduit_t cur;
        int       held;
        cur.delay = 99; cur.aborted = 1'b1; cur.wr = 1'b0; cur.addr = '0;
        cur.be = 4'h0; cur.wdata = 32'h0; cur.rdata = 32'h0;
        held = 0;
        forever begin
            @(negedge clk_clk);
            if (sdram_read || sdram_write) begin
                if (!in_txn) begin
                    check("strobe_expected", {31'h0, cq.size() > 0}, 32'h1);
                    if (cq.size() > 0) cur = cq.pop_front();
                    else begin cur.delay = 99; cur.aborted = 1'b1; end
                    in_txn = 1'b1;
                    held = 0;
                end
                check("strobe_dir", {30'h0, sdram_write, sdram_read}, cur.wr ? 32'h2 : 32'h1);
                check("sdram_address", {16'h0, sdram_address}, {16'h0, cur.addr});
                check("sdram_byte_enable", {28'h0, sdram_byte_enable}, {28'h0, cur.be});
                if (cur.wr) check("sdram_write_data", sdram_write_data, cur.wdata);
                if (held == cur.delay) begin resp_ack = 1'b1; sdram_read_data = cur.rdata; end
                else begin resp_ack = 1'b0; sdram_read_data = $urandom; end
                held++;
            end else begin
                resp_ack = 1'b0;
                sdram_read_data = $urandom;
                if (in_txn) begin
                    in_txn = 1'b0;
                    if (!cur.aborted)
                        check("strobe_cycles", 32'(held), 32'(cur.delay < TO ? cur.delay + 1 : TO));
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin : rsp_monitor
        rsp_t        e;
        logic [31:0] last_rdata;
        bit          prev_valid;
        last_rdata = 32'h0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk_clk);
            if (reset_reset) begin
                last_rdata = 32'h0;
            end else if (cpu_rsp_valid) begin
                check("rsp_single_pulse", {31'h0, prev_valid}, 32'h0);
                check("rsp_expected", {31'h0, rq.size() > 0}, 32'h1);
                if (rq.size() > 0) begin
                    e = rq.pop_front();
                    check("rsp_error", {31'h0, cpu_rsp_error}, {31'h0, e.err});
                    check("rsp_rdata", cpu_rsp_rdata, e.rdata);
                    last_rdata = e.rdata;
                end
            end else begin
                check("rsp_rdata_hold", cpu_rsp_rdata, last_rdata);
            end
            prev_valid = cpu_rsp_valid;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        logic [AW+1:0] a;
        int            sz;
        repeat (3) @(negedge clk_clk);
        check("reset_ready", {31'h0, cpu_req_ready}, 32'h1);
        check("reset_rsp", {30'h0, cpu_rsp_valid, cpu_rsp_error}, 32'h0);
        check("reset_rdata", cpu_rsp_rdata, 32'h0);
        check("reset_strobes", {30'h0, sdram_read, sdram_write}, 32'h0);
        check("reset_addr_be", {12'h0, sdram_address, sdram_byte_enable}, 32'h0);
        check("reset_wdata", sdram_write_data, 32'h0);
        #2 reset_reset = 1'b0;
        @(negedge clk_clk);

        // Word store, strobe held 3 cycles.
        issue(1'b1, 18'h00010, 2, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1'b0);
        // Byte load from lane 2.
        issue(1'b0, 18'h00006, 0, 32'h0, 1, 32'h11223344, 1'b1, 1'b0);
        // Misaligned half: error, no conduit activity.
        issue(1'b1, 18'h00003, 1, 32'h1234, 0, 32'h0, 1'b1, 1'b0);
        // Timeout with ack held low, then a stray late ack.
        issue(1'b0, 18'h00008, 2, 32'h0, 10, 32'h0, 1'b1, 1'b0);
        wait_idle();
        repeat (2) @(negedge clk_clk);
        stray_ack = 1'b1;
        @(negedge clk_clk);
        stray_ack = 1'b0;
        repeat (4) @(negedge clk_clk);

        // Reset while a store strobe is high.
        issue(1'b1, 18'h00020, 2, 32'hCAFEF00D, 0, 32'h0, 1'b0, 1'b1);
        check("abort_strobe_high", {31'h0, sdram_write}, 32'h1);
        #2 reset_reset = 1'b1;
        @(negedge clk_clk);
        check("abort_strobes_low", {30'h0, sdram_read, sdram_write}, 32'h0);
        check("abort_ready", {31'h0, cpu_req_ready}, 32'h1);
        check("abort_no_rsp", {31'h0, cpu_rsp_valid}, 32'h0);
        #2 reset_reset = 1'b0;
        @(negedge clk_clk);
        issue(1'b1, 18'h00002, 1, 32'h0000ABCD, 0, 32'h0, 1'b0, 1'b0);

        // Back-to-back loads acknowledged in the first strobe cycle.
        for (int i = 0; i < 6; i++) begin
            sz = $urandom_range(0, 2);
            a = 18'($urandom) & ~18'((1 << sz) - 1);
            issue(1'b0, a, sz, 32'h0, 0, $urandom, 1'b1, 1'b0);
        end

        // Random mix including illegal sizes and timeouts.
        for (int i = 0; i < 150; i++) begin
            sz = $urandom_range(0, 3);
            a = 18'($urandom);
            if ($urandom_range(0, 3) != 0 && sz != 3) a = a & ~18'((1 << sz) - 1);
            issue(1'($urandom), a, sz, $urandom, $urandom_range(0, 5), $urandom, 1'b1, 1'b0);
        end

        wait_idle();
        repeat (3) @(negedge clk_clk);
        check("rsp_queue_drained", 32'(rq.size()), 32'h0);
        check("conduit_queue_drained", 32'(cq.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sdram_master_port.md
Name: sdram_master_port

Overview:
- FPGA-side initiator for the HPS SDRAM conduit (sdram_address/byte_enable/read/write/write_data, sdram_acknowledge/read_data).
- Converts single-outstanding CPU byte/half/word load-store requests into 32-bit word-addressed conduit transactions with byte enables.
- Holds each strobe until acknowledge, or until a timeout fires, then returns one response pulse to the stack CPU.

Parameters:
- ADDR_WIDTH, 16, conduit word-address width; CPU byte address is ADDR_WIDTH+2 bits.
- TIMEOUT_CYCLES, 255, max cycles a strobe is held without acknowledge before an error response (>=1).

Ports:
- clk_clk  input  1  single clock; all logic on rising edge.
- reset_reset  input  1  synchronous, active-high reset.
- cpu_req_valid  input  1  request present.
- cpu_req_ready  output  1  block can accept; high only in IDLE.
- cpu_req_write  input  1  1=store, 0=load.
- cpu_req_addr  input  ADDR_WIDTH+2  byte address.
- cpu_req_size  input  2  0=byte, 1=half, 2=word, 3=reserved.
- cpu_req_wdata  input  32  store data, right-justified.
- cpu_rsp_valid  output  1  one-cycle response pulse.
- cpu_rsp_rdata  output  32  load data, zero-extended, right-justified; 0 for stores and errors.
- cpu_rsp_error  output  1  qualifies cpu_rsp_valid: misaligned, reserved size, or timeout.
- sdram_address  output  ADDR_WIDTH  word address = cpu_req_addr[ADDR_WIDTH+1:2].
- sdram_byte_enable  output  4  lane enables.
- sdram_read  output  1  read strobe.
- sdram_write  output  1  write strobe.
- sdram_write_data  output  32  lane-placed store data.
- sdram_acknowledge  input  1  transfer complete; read_data valid in the same cycle.
- sdram_read_data  input  32  read data.

Behaviour:
- Reset: state=IDLE. cpu_req_ready=1. cpu_rsp_valid=0, cpu_rsp_error=0, cpu_rsp_rdata=0. sdram_read=0, sdram_write=0, sdram_address=0, sdram_byte_enable=0, sdram_write_data=0. Timeout counter=0.
- Reset mid-transaction: strobes drop the next cycle; no response is issued.
- States:
  - IDLE: on valid&ready, latch the request.
    - Legal request: go to REQ.
    - Illegal request (size=3; half with addr[0]=1; word with addr[1:0]!=0): go to RSP with error=1. No conduit activity.
  - REQ: sdram_read or sdram_write is high, with address, byte_enable and write_data stable and registered.
    - Counter increments each REQ cycle.
    - acknowledge sampled high: drop strobe next cycle, capture read_data, go to RSP.
    - Counter reaches TIMEOUT_CYCLES without ack: drop strobe, go to RSP with error=1.
    - Ack on the same edge as timeout: ack wins, no error.
  - RSP: cpu_rsp_valid=1 for exactly one cycle, then IDLE. No backpressure on the response.
- Latency:
  - Request accepted on edge N: strobe high in cycle N+1.
  - Ack sampled on edge M: strobe low and cpu_rsp_valid high in cycle M+1.
  - cpu_req_ready high again in cycle M+2.
  - Minimum request-to-request spacing is 3 cycles (ack in first REQ cycle).
- Lane placement, b = addr[1:0]:
  - byte: byte_enable = 1<<b; write_data = wdata[7:0] replicated x4.
  - half: byte_enable = 4'b0011 (b=0) or 4'b1100 (b=2); write_data = wdata[15:0] replicated x2.
  - word: byte_enable = 4'b1111; write_data = wdata.
  - Loads use the same byte_enable.
- Read extraction:
  - byte: rdata = {24'b0, read_data[8b+7:8b]}.
  - half: rdata = {16'b0, selected half}.
  - word: rdata = read_data.
- read and write strobes are never both high.
- acknowledge while not in REQ is ignored. sdram_read_data is sampled only on ack in REQ.
- cpu_rsp_rdata holds its value between responses; it is cleared only by reset or by a store/error response.

Test Plan:
1. Word store: addr=0x00010, size=2, wdata=0xDEADBEEF, ack 3 cycles after strobe -> address=0x0004, byte_enable=4'hF, write_data=0xDEADBEEF; strobe held 3 cycles; rsp_valid one cycle, error=0, rdata=0.
2. Byte load: addr=0x00006, read_data=0x11223344 on ack -> byte_enable=4'b0100, address=0x0001; rdata=0x00000022.
3. Misaligned half: addr=0x00003, size=1 -> no sdram strobe ever; rsp_valid+error at cycle N+1; ready returns at N+2.
4. Timeout: TIMEOUT_CYCLES=4, ack held low -> sdram_read high exactly 4 cycles; error response follows. A late ack 2 cycles later is ignored: no second response.
5. Reset mid-REQ: assert reset_reset while sdram_write is high -> strobe low next cycle; no rsp_valid; ready=1. A new half store of 0xABCD at addr 2 then gives byte_enable=4'b1100, write_data=0xABCDABCD.
6. Back-to-back loads, ack in first REQ cycle each -> 3-cycle spacing. read and write strobes never overlap; each response's rdata matches its own ack data.
